// File: rtl/benes_cfg_loader.sv
// Double-banked switch-setting loader and ingress register for a pipelined Benes network.
// Optional host-error checking (cfg_err port, written-mask) is enabled by defining BENES_CFG_CHECK_EN.
module benes_cfg_loader #(
  parameter  int SIZE       = 8,
  parameter  int DATA_WIDTH = 4,
  parameter  int STAGE_LAT  = 2,
  localparam int LAYER_NUM  = $clog2(SIZE),
  localparam int STAGE_NUM  = 2*LAYER_NUM-1,
  localparam int SWITCH_NUM = SIZE/2,
  localparam int PIPE_LEN   = STAGE_NUM*STAGE_LAT,
  localparam int STG_W      = $clog2(STAGE_NUM)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [STG_W-1:0]      cfg_stage,
  input  logic [SWITCH_NUM-1:0] cfg_bits,
  input  logic                  cfg_last,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_port    [0:SIZE-1],
  output logic [DATA_WIDTH-1:0] net_port   [0:SIZE-1],
  output logic                  net_valid,
  output logic [SWITCH_NUM-1:0] switch_set [0:STAGE_NUM-1],
  output logic                  out_valid,
  output logic                  active_bank
`ifdef BENES_CFG_CHECK_EN
  ,
  output logic                  cfg_err
`endif
);

  localparam logic [STG_W:0] StageLimit = (STG_W+1)'(STAGE_NUM);

  logic [SWITCH_NUM-1:0] bank_q [0:1][0:STAGE_NUM-1];
  logic                  activeBank_q, activeBank_d;
  logic                  shadowBank;
  logic [PIPE_LEN-1:0]   tagValid_q, tagValid_d;
  logic [PIPE_LEN-1:0]   tagBank_q, tagBank_d;
  logic [DATA_WIDTH-1:0] netPort_q [0:SIZE-1];
  logic                  netValid_q, netValid_d;
  logic                  outValid_q, outValid_d;
  logic                  stageOk, cfgAccept, cfgWrite, cfgCommit;

  assign shadowBank = ~activeBank_q;
  assign stageOk    = ({1'b0, cfg_stage} < StageLimit);
  assign cfgAccept  = cfg_valid && cfg_ready;
  assign cfgWrite   = cfgAccept && stageOk;
  assign cfgCommit  = cfgAccept && cfg_last;

  // The shadow bank stays locked while any in-flight vector was launched against it.
  assign cfg_ready = ~|(tagValid_q & (tagBank_q ^ {PIPE_LEN{activeBank_q}}));

  always_comb begin
    activeBank_d = cfgCommit ? shadowBank : activeBank_q;
    tagValid_d   = {tagValid_q[PIPE_LEN-2:0], in_valid};
    tagBank_d    = {tagBank_q[PIPE_LEN-2:0], activeBank_q};
    netValid_d   = in_valid;
    outValid_d   = tagValid_q[PIPE_LEN-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < STAGE_NUM; s++) begin
          bank_q[b][s] <= '0;
        end
      end
    end else if (cfgWrite) begin
      bank_q[shadowBank][cfg_stage] <= cfg_bits;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      activeBank_q <= 1'b0;
      tagValid_q   <= '0;
      tagBank_q    <= '0;
      netValid_q   <= 1'b0;
      outValid_q   <= 1'b0;
      for (int i = 0; i < SIZE; i++) begin
        netPort_q[i] <= '0;
      end
    end else begin
      activeBank_q <= activeBank_d;
      tagValid_q   <= tagValid_d;
      tagBank_q    <= tagBank_d;
      netValid_q   <= netValid_d;
      outValid_q   <= outValid_d;
      if (in_valid) begin
        for (int i = 0; i < SIZE; i++) begin
          netPort_q[i] <= in_port[i];
        end
      end
    end
  end

  // Each stage follows the bank recorded with the vector currently at its input.
  always_comb begin
    for (int k = 0; k < STAGE_NUM; k++) begin
      switch_set[k] = bank_q[tagBank_q[k*STAGE_LAT]][k];
    end
  end

  assign net_port    = netPort_q;
  assign net_valid   = netValid_q;
  assign out_valid   = outValid_q;
  assign active_bank = activeBank_q;

`ifdef BENES_CFG_CHECK_EN
  logic [STAGE_NUM-1:0] writtenMask_q, writtenMask_d, stageHit;
  logic                 cfgErr_q, cfgErr_d;

  // A commit counts its own word as written before judging completeness.
  always_comb begin
    stageHit = '0;
    if (cfgWrite) begin
      stageHit[cfg_stage] = 1'b1;
    end
    writtenMask_d = cfgCommit ? '0 : (writtenMask_q | stageHit);
    cfgErr_d      = cfgErr_q;
    if (cfgAccept && !stageOk) begin
      cfgErr_d = 1'b1;
    end
    if (cfgCommit && !(&(writtenMask_q | stageHit))) begin
      cfgErr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      writtenMask_q <= '0;
      cfgErr_q      <= 1'b0;
    end else begin
      writtenMask_q <= writtenMask_d;
      cfgErr_q      <= cfgErr_d;
    end
  end

  assign cfg_err = cfgErr_q;
`endif

endmodule

// File: tb/tb_benes_cfg_loader.sv
// Self-checking bench for benes_cfg_loader: per-cycle comparison against a history-based
// model of launched vectors and bank contents, plus directed literal checks.
module tb_benes_cfg_loader;

  localparam int SIZE       = 8;
  localparam int DATA_WIDTH = 4;
  localparam int STAGE_NUM  = 5;
  localparam int SWITCH_NUM = 4;
  localparam int STAGE_LAT  = 2;
  localparam int PIPE_LEN   = 10;
  localparam int HIST       = 4096;

  logic                  clk;
  logic                  rst_n;
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [2:0]            cfg_stage;
  logic [SWITCH_NUM-1:0] cfg_bits;
  logic                  cfg_last;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_port    [0:SIZE-1];
  logic [DATA_WIDTH-1:0] net_port   [0:SIZE-1];
  logic                  net_valid;
  logic [SWITCH_NUM-1:0] switch_set [0:STAGE_NUM-1];
  logic                  out_valid;
  logic                  active_bank;
`ifdef BENES_CFG_CHECK_EN
  logic                  cfg_err;
`endif

  benes_cfg_loader #(.SIZE(SIZE), .DATA_WIDTH(DATA_WIDTH), .STAGE_LAT(STAGE_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_stage  (cfg_stage),
    .cfg_bits   (cfg_bits),
    .cfg_last   (cfg_last),
    .in_valid   (in_valid),
    .in_port    (in_port),
    .net_port   (net_port),
    .net_valid  (net_valid),
    .switch_set (switch_set),
    .out_valid  (out_valid),
    .active_bank(active_bank)
`ifdef BENES_CFG_CHECK_EN
    ,
    .cfg_err    (cfg_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: bank contents, active bank, and a per-cycle history of what was launched.
  logic [SWITCH_NUM-1:0] mBank [0:1][0:STAGE_NUM-1];
  logic                  mActive = 1'b0;
  logic [STAGE_NUM-1:0]  mMask = '0;
  logic                  mErr = 1'b0;
  logic                  mRdy;
  logic [DATA_WIDTH-1:0] mNetPort [0:SIZE-1];
  logic                  histValid [0:HIST-1];
  logic                  histBank  [0:HIST-1];
  int                    cyc = 0;
  int                    histFloor = 0;

  function automatic logic validAt(input int idx);
    if (idx < 0 || idx < histFloor || idx >= HIST) return 1'b0;
    return histValid[idx];
  endfunction

  function automatic logic bankAt(input int idx);
    if (idx < 0 || idx < histFloor || idx >= HIST) return 1'b0;
    return histBank[idx];
  endfunction

  function automatic logic modelReady();
    for (int j = 0; j < PIPE_LEN; j++) begin
      if (validAt(cyc-1-j) && (bankAt(cyc-1-j) != mActive)) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int s = 0; s < STAGE_NUM; s++)
          mBank[b][s] = '0;
      for (int i = 0; i < SIZE; i++) mNetPort[i] = '0;
      mActive = 1'b0;
      mMask = '0;
      mErr = 1'b0;
      cyc++;
      histFloor = cyc;
    end else begin
      mRdy = modelReady();
      if (cyc < HIST) begin
        histValid[cyc] = in_valid;
        histBank[cyc]  = mActive;
      end
      if (in_valid) mNetPort = in_port;
      if (cfg_valid && mRdy) begin
        if (int'(cfg_stage) < STAGE_NUM) begin
          mBank[~mActive][cfg_stage] = cfg_bits;
          mMask[cfg_stage] = 1'b1;
        end else begin
          mErr = 1'b1;
        end
        if (cfg_last) begin
          if (mMask != '1) mErr = 1'b1;
          mActive = ~mActive;
          mMask = '0;
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("cfg_ready", 32'(cfg_ready), 32'(modelReady()));
      checkOutput("active_bank", 32'(active_bank), 32'(mActive));
      checkOutput("net_valid", 32'(net_valid), 32'(validAt(cyc-1)));
      checkOutput("out_valid", 32'(out_valid), 32'(validAt(cyc-1-PIPE_LEN)));
      for (int i = 0; i < SIZE; i++)
        checkOutput($sformatf("net_port[%0d]", i), 32'(net_port[i]), 32'(mNetPort[i]));
      for (int k = 0; k < STAGE_NUM; k++)
        checkOutput($sformatf("switch_set[%0d]", k), 32'(switch_set[k]),
                    32'(mBank[bankAt(cyc-1-k*STAGE_LAT)][k]));
`ifdef BENES_CFG_CHECK_EN
      checkOutput("cfg_err", 32'(cfg_err), 32'(mErr));
`endif
    end
  end

  task automatic applyStimulus(input logic cv, input logic [2:0] st, input logic [3:0] bits,
                               input logic last, input logic iv);
    cfg_valid = cv;
    cfg_stage = st;
    cfg_bits  = bits;
    cfg_last  = last;
    in_valid  = iv;
    for (int i = 0; i < SIZE; i++) in_port[i] = 4'($urandom);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  logic [3:0] litA [0:STAGE_NUM-1];
  int lowCount;
  int dens;

  initial begin
    litA[0] = 4'h1; litA[1] = 4'h2; litA[2] = 4'h4; litA[3] = 4'h8; litA[4] = 4'hF;
    cfg_valid = 1'b0; cfg_stage = '0; cfg_bits = '0; cfg_last = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < SIZE; i++) in_port[i] = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    for (int k = 0; k < STAGE_NUM; k++)
      checkOutput($sformatf("lit_reset_switch_set[%0d]", k), 32'(switch_set[k]), 32'h0);
    checkOutput("lit_reset_cfg_ready", 32'(cfg_ready), 32'h1);
    checkOutput("lit_reset_active_bank", 32'(active_bank), 32'h0);
    checkOutput("lit_reset_out_valid", 32'(out_valid), 32'h0);
    @(posedge clk);
    #1;

    // Load bank 1, commit on stage 4, then launch one vector right away.
    for (int s = 0; s < STAGE_NUM; s++)
      applyStimulus(1'b1, 3'(s), litA[s], (s == STAGE_NUM-1), 1'b0);
    applyStimulus(1'b0, 3'd0, 4'h0, 1'b0, 1'b1);
    for (int d = 1; d <= 11; d++) begin
      @(negedge clk);
      if (d == 1) checkOutput("lit_active_after_commit", 32'(active_bank), 32'h1);
      for (int k = 0; k < STAGE_NUM; k++) begin
        if (d == 1 + 2*k)
          checkOutput($sformatf("lit_wave_switch_set[%0d]", k), 32'(switch_set[k]), 32'(litA[k]));
        else if (d == 2*k)
          checkOutput($sformatf("lit_prewave_switch_set[%0d]", k), 32'(switch_set[k]), 32'h0);
      end
      checkOutput($sformatf("lit_out_valid_d%0d", d), 32'(out_valid), 32'(d == 11));
      @(posedge clk);
      #1;
    end

    // Commit and launch in the same cycle; count how long the old bank stays locked.
    applyStimulus(1'b1, 3'd0, 4'hA, 1'b1, 1'b1);
    in_valid = 1'b1;
    lowCount = 0;
    for (int d = 1; d <= 14; d++) begin
      @(negedge clk);
      if (!cfg_ready) lowCount++;
      if (d == 1) begin
        checkOutput("lit_same_cycle_old_bank", 32'(switch_set[0]), 32'h1);
        checkOutput("lit_active_flipped", 32'(active_bank), 32'h0);
      end
      if (d == 2) checkOutput("lit_next_vec_new_bank", 32'(switch_set[0]), 32'hA);
      if (d == 3) checkOutput("lit_old_vec_stage1", 32'(switch_set[1]), 32'h2);
      if (d == 4) checkOutput("lit_new_vec_stage1", 32'(switch_set[1]), 32'h0);
      if (d == 11) checkOutput("lit_ready_reopens", 32'(cfg_ready), 32'h1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    checkOutput("lit_ready_low_cycles", 32'(lowCount), 32'd10);

    // Randomized traffic with a mid-run reset.
    dens = 2;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) dens = $urandom_range(0, 4);
      if (i == 700) doReset();
      applyStimulus(($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), 4'($urandom),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) < dens));
    end

`ifdef BENES_CFG_CHECK_EN
    doReset();
    for (int s = 0; s < STAGE_NUM; s++)
      applyStimulus(1'b1, 3'(s), litA[s], (s == STAGE_NUM-1), 1'b0);
    applyStimulus(1'b1, 3'd0, 4'h5, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd1, 4'h6, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd2, 4'h7, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd3, 4'h9, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd4, 4'hB, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("lit_err_clean_commits", 32'(cfg_err), 32'h0);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 3'd0, 4'h3, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd4, 4'hC, 1'b1, 1'b0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    checkOutput("lit_partial_err", 32'(cfg_err), 32'h1);
    checkOutput("lit_partial_active", 32'(active_bank), 32'h1);
    checkOutput("lit_partial_s0", 32'(switch_set[0]), 32'h3);
    checkOutput("lit_partial_s1", 32'(switch_set[1]), 32'h2);
    checkOutput("lit_partial_s2", 32'(switch_set[2]), 32'h4);
    checkOutput("lit_partial_s3", 32'(switch_set[3]), 32'h8);
    checkOutput("lit_partial_s4", 32'(switch_set[4]), 32'hC);
    @(posedge clk);
    #1;
    doReset();
    applyStimulus(1'b1, 3'd7, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("lit_badstage_err", 32'(cfg_err), 32'h1);
    checkOutput("lit_badstage_active", 32'(active_bank), 32'h0);
    @(posedge clk);
    #1;
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/benes_cfg_loader.md
# benes_cfg_loader

Configuration and ingress stage placed directly upstream of the pipelined Benes network. It accepts per-stage switch-setting words from a host over a valid/ready handshake into a shadow bank and commits them atomically. It registers input data vectors into the network's stage-0 input. It drives each network stage's `switch_set` lane skewed to the data wavefront, so every vector traverses the whole network under one consistent configuration, even while a new configuration is being loaded.

## Interface
- `SIZE`, 8, network port count (power of two, ≥4)
- `DATA_WIDTH`, 4, bits per port
- `LAYER_NUM`, $clog2(SIZE), derived
- `STAGE_NUM`, 2*LAYER_NUM-1, derived switch stages
- `SWITCH_NUM`, SIZE/2, derived switches per stage
- `STAGE_LAT`, 2, clock cycles between consecutive network stage inputs
- `PIPE_LEN`, STAGE_NUM*STAGE_LAT, derived tag-pipe depth
- `STG_W`, $clog2(STAGE_NUM), derived

Ports:
- `clk`  in  1  clock; one clock, all logic rising-edge
- `rst_n`  in  1  asynchronous active-low reset
- `cfg_valid`  in  1  host config word valid
- `cfg_ready`  out  1  loader can accept a config word
- `cfg_stage`  in  STG_W  target stage index
- `cfg_bits`  in  SWITCH_NUM  switch settings for that stage (bit i = switch i crossed)
- `cfg_last`  in  1  final word; commit shadow bank on acceptance
- `in_valid`  in  1  data vector present (no backpressure; network is free-running)
- `in_port`  in  DATA_WIDTH × [0:SIZE-1]  data vector
- `net_port`  out  DATA_WIDTH × [0:SIZE-1]  to network `i_port`
- `net_valid`  out  1  `net_port` holds a new vector this cycle
- `switch_set`  out  SWITCH_NUM × [0:STAGE_NUM-1]  to network `switch_set`
- `out_valid`  out  1  vector exits the last stage this cycle
- `active_bank`  out  1  bank index new vectors will use
- `cfg_err`  out  1  sticky error (present only with the macro)

## Operation
- Two banks, each STAGE_NUM × SWITCH_NUM bits. Each bank is either active (used by new vectors) or shadow (host-writable).
- Reset: both banks zero, `active_bank`=0, shadow=1, tag pipe all invalid with bank field 0, `net_port` zero, `net_valid`/`out_valid`/`cfg_err` 0, written-mask zero.
- Config write: on `cfg_valid && cfg_ready`, `bank[shadow][cfg_stage] <= cfg_bits` and set written-mask bit `cfg_stage`. If `cfg_stage` ≥ STAGE_NUM, the write is dropped.
- Commit: on an accepted word with `cfg_last`=1, the word is written first, then at the same edge `active_bank <= shadow`, shadow takes the old active bank, and the written-mask clears. Unwritten stages keep their previous contents.
- Tag pipe: PIPE_LEN entries of {valid, bank}, shifted every cycle. Entry 0 loads {`in_valid`, `active_bank`} at the same edge that `net_port` loads.
- `switch_set[k]` = `bank[tag[k*STAGE_LAT].bank][k]`. This is combinational from registered state.
- `out_valid` = `tag[PIPE_LEN-1].valid` registered by one cycle.
- `cfg_ready` = NOT (any valid tag entry whose bank equals shadow). After a commit, loading is stalled until vectors launched under the old bank drain.
- `net_port`: loads `in_port` when `in_valid`=1 and holds otherwise. `net_valid` is registered `in_valid`.

## Timing
- Data latency into the network is 1 cycle (`in_port` → `net_port`).
- Stage k receives vector v at cycle t+1+k*STAGE_LAT. `switch_set[k]` carries v's bank for that cycle.
- `out_valid` asserts at cycle t+1+PIPE_LEN for input at cycle t.
- If `in_valid` and a commit occur in the same cycle, the vector uses the pre-commit active bank.
- Back-to-back commits are allowed only through `cfg_ready`. The second bank is never written while referenced.
- Reset mid-operation clears all in-flight tags and returns to reset state. Bank contents return to zero.

## Configuration
- `BENES_CFG_CHECK_EN` defined:
  - `cfg_err` is present.
  - `cfg_err` is set by an out-of-range `cfg_stage`, or by a commit when the written-mask is not all ones (the `cfg_last` word's own stage counts as written).
  - The commit still occurs.
  - `cfg_err` clears only on reset.
- `BENES_CFG_CHECK_EN` undefined: no `cfg_err` port, no written-mask logic; bad stages are silently dropped.

## Test plan
- Reset, defaults (SIZE=8, STAGE_LAT=2) → all `switch_set`=4'h0, `cfg_ready`=1, `active_bank`=0, `out_valid`=0.
- Write stages 0–4 with 4'h1,4'h2,4'h4,4'h8,4'hF, `cfg_last` on stage 4, then one vector → `active_bank`=1; `switch_set[k]` shows the bank-1 value exactly at cycle t+1+2k; `out_valid` at t+11.
- Stream a vector every cycle, commit a second config mid-stream → stages show old values for pre-commit vectors and new values for later ones, never mixed within a vector.
- Commit, then immediately attempt another load → `cfg_ready`=0 for 10 cycles after the last old-bank vector launch, then 1.
- `cfg_valid`, `cfg_last`, and `in_valid` in the same cycle → that vector uses the old bank; the next vector uses the new bank.
- With `BENES_CFG_CHECK_EN`: `cfg_stage`=7 → `cfg_err`=1 and no bank change; separately, commit after writing only stages 0 and 4 → `cfg_err`=1 and stages 1–3 keep prior values.
